// File: rtl/wb_stage_pkg.sv
// Shared encodings for the MIPS writeback stage: result-select, load types,
// FSM states and the pending-load record held while waiting on data memory.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2,
    WB_RSVD = 2'd3
  } wbsel_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4
  } ldtype_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

  typedef struct packed {
    logic       regwrite;
    logic [4:0] rd;
    logic [2:0] ldtype;
    logic [1:0] addr_lo;
  } pend_s;

  // $0 is hardwired to zero, so a write to it is suppressed but still retires.
  function automatic logic writes_reg(input logic rw, input logic [4:0] rd);
    return rw & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the writeback stage's MEM-side handshake, data-memory return
// channel and RegBank write port.
interface wb_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_regwrite;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wbsel;
  logic [2:0]  ex_ldtype;
  logic [1:0]  ex_addr_lo;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_link_pc;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        regwrite;
  logic [4:0]  wreg;
  logic [31:0] WriteData;
  logic        retire;
  logic        protocol_err;

  modport slave (
    input  ex_valid, ex_regwrite, ex_rd, ex_wbsel, ex_ldtype, ex_addr_lo,
           ex_alu_result, ex_link_pc, dmem_rvalid, dmem_rdata,
    output ex_ready, regwrite, wreg, WriteData, retire, protocol_err
  );

  modport master (
    output ex_valid, ex_regwrite, ex_rd, ex_wbsel, ex_ldtype, ex_addr_lo,
           ex_alu_result, ex_link_pc, dmem_rvalid, dmem_rdata,
    input  ex_ready, regwrite, wreg, WriteData, retire, protocol_err
  );
endinterface

// File: rtl/wb_stage_load_extend.sv
// Selects the addressed byte/halfword of a little-endian load word and
// sign- or zero-extends it to 32 bits.
module wb_stage_load_extend
  import wb_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  ldtype_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    // Halfword accesses ignore addr bit 0.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (ldtype_i)
      LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {24'd0, byte_sel};
      LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: retires ALU/link results in one cycle, parks loads
// until data memory answers (or times out) and drives RegBank's write port.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  bus
);

  localparam int unsigned CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  pend_s             pend_q, pend_d;
  logic              regwrite_q, regwrite_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              retire_q, retire_d;
  logic              perr_q, perr_d;
  logic [31:0]       load_data;

  wb_stage_load_extend u_ext (
    .rdata_i   (bus.dmem_rdata),
    .ldtype_i  (pend_q.ldtype),
    .addr_lo_i (pend_q.addr_lo),
    .data_o    (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    regwrite_d = 1'b0;
    retire_d   = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    perr_d     = perr_q;

    case (state_q)
      ST_IDLE: begin
        // Load data with no load outstanding is a protocol violation; drop it.
        if (bus.dmem_rvalid) perr_d = 1'b1;
        if (bus.ex_valid) begin
          if (bus.ex_wbsel == WB_LOAD) begin
            pend_d.regwrite = bus.ex_regwrite;
            pend_d.rd       = bus.ex_rd;
            pend_d.ldtype   = bus.ex_ldtype;
            pend_d.addr_lo  = bus.ex_addr_lo;
            cnt_d           = '0;
            state_d         = ST_WAIT_MEM;
          end else begin
            regwrite_d = writes_reg(bus.ex_regwrite, bus.ex_rd);
            wreg_d     = bus.ex_rd;
            wdata_d    = (bus.ex_wbsel == WB_LINK) ? bus.ex_link_pc : bus.ex_alu_result;
            retire_d   = 1'b1;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (bus.dmem_rvalid) begin
          regwrite_d = writes_reg(pend_q.regwrite, pend_q.rd);
          wreg_d     = pend_q.rd;
          wdata_d    = load_data;
          retire_d   = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Give up on the load: retire it without a write and flag the error.
          retire_d = 1'b1;
          perr_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= 5'd0;
      wdata_q    <= 32'd0;
      retire_q   <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      retire_q   <= retire_d;
      perr_q     <= perr_d;
    end
  end

  assign bus.ex_ready     = (state_q == ST_IDLE);
  assign bus.regwrite     = regwrite_q;
  assign bus.wreg         = wreg_q;
  assign bus.WriteData    = wdata_q;
  assign bus.retire       = retire_q;
  assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table of single instructions plus
// hand-written sequences for load waits, timeout, stray data and reset.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int unsigned LT = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  wb_stage_if bus ();

  wb_stage #(.LOAD_TIMEOUT(LT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wbsel;
    logic        rw;
    logic [4:0]  rd;
    logic [2:0]  ldtype;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] link;
    logic [31:0] rdata;
    logic        exp_rw;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [1:0] wbsel, logic rw, logic [4:0] rd,
                              logic [2:0] ldtype, logic [1:0] addr_lo,
                              logic [31:0] alu, logic [31:0] link, logic [31:0] rdata,
                              logic exp_rw, logic [4:0] exp_wreg, logic [31:0] exp_wdata);
    vec_t v;
    v.wbsel = wbsel; v.rw = rw; v.rd = rd; v.ldtype = ldtype; v.addr_lo = addr_lo;
    v.alu = alu; v.link = link; v.rdata = rdata;
    v.exp_rw = exp_rw; v.exp_wreg = exp_wreg; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ex_valid = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_rd = 5'd0;
    bus.ex_wbsel = 2'd0; bus.ex_ldtype = 3'd0; bus.ex_addr_lo = 2'd0;
    bus.ex_alu_result = 32'd0; bus.ex_link_pc = 32'd0;
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
  endtask

  task automatic drive(input logic [1:0] wbsel, input logic rw, input logic [4:0] rd,
                       input logic [2:0] ldtype, input logic [1:0] addr_lo,
                       input logic [31:0] alu, input logic [31:0] link);
    bus.ex_valid = 1'b1; bus.ex_wbsel = wbsel; bus.ex_regwrite = rw; bus.ex_rd = rd;
    bus.ex_ldtype = ldtype; bus.ex_addr_lo = addr_lo;
    bus.ex_alu_result = alu; bus.ex_link_pc = link;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a load, wait `gap` idle cycles, then return rdata; checks afterwards.
  task automatic load_seq(input string nm, input logic [2:0] ldtype, input logic [1:0] addr_lo,
                          input logic [4:0] rd, input logic [31:0] rdata, input int gap,
                          input logic [31:0] exp);
    drive(WB_LOAD, 1'b1, rd, ldtype, addr_lo, 32'h0, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    for (int k = 0; k < gap; k++) begin
      check({nm, "_ready_wait"}, {31'd0, bus.ex_ready}, 32'd0);
      check({nm, "_retire_wait"}, {31'd0, bus.retire}, 32'd0);
      step();
    end
    check({nm, "_ready_last"}, {31'd0, bus.ex_ready}, 32'd0);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdata;
    step();
    bus.dmem_rvalid = 1'b0;
    check({nm, "_regwrite"}, {31'd0, bus.regwrite}, 32'd1);
    check({nm, "_wreg"}, {27'd0, bus.wreg}, {27'd0, rd});
    check({nm, "_wdata"}, bus.WriteData, exp);
    check({nm, "_retire"}, {31'd0, bus.retire}, 32'd1);
    check({nm, "_ready_back"}, {31'd0, bus.ex_ready}, 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    clear_inputs();

    vecs[0]  = mk(WB_ALU,  1, 5'd3,  3'd0,   2'd0, 32'd178,       32'h0,         32'h0,         1, 5'd3,  32'd178);
    vecs[1]  = mk(WB_LINK, 1, 5'd31, 3'd0,   2'd0, 32'd5,         32'h0040_0010, 32'h0,         1, 5'd31, 32'h0040_0010);
    vecs[2]  = mk(WB_RSVD, 1, 5'd7,  3'd0,   2'd0, 32'h0000_1234, 32'h0000_9999, 32'h0,         1, 5'd7,  32'h0000_1234);
    vecs[3]  = mk(WB_ALU,  1, 5'd0,  3'd0,   2'd0, 32'd13,        32'h0,         32'h0,         0, 5'd0,  32'd13);
    vecs[4]  = mk(WB_ALU,  0, 5'd5,  3'd0,   2'd0, 32'd7,         32'h0,         32'h0,         0, 5'd5,  32'd7);
    vecs[5]  = mk(WB_LOAD, 1, 5'd8,  LD_LBU, 2'd1, 32'h0,         32'h0,         32'h1122_8344, 1, 5'd8,  32'h0000_0083);
    vecs[6]  = mk(WB_LOAD, 1, 5'd9,  LD_LB,  2'd1, 32'h0,         32'h0,         32'h1122_8344, 1, 5'd9,  32'hFFFF_FF83);
    vecs[7]  = mk(WB_LOAD, 1, 5'd10, LD_LH,  2'd0, 32'h0,         32'h0,         32'hBEEF_8001, 1, 5'd10, 32'hFFFF_8001);
    vecs[8]  = mk(WB_LOAD, 1, 5'd11, LD_LHU, 2'd1, 32'h0,         32'h0,         32'hBEEF_8001, 1, 5'd11, 32'h0000_8001);
    vecs[9]  = mk(WB_LOAD, 1, 5'd12, LD_LW,  2'd0, 32'h0,         32'h0,         32'hDEAD_BEEF, 1, 5'd12, 32'hDEAD_BEEF);
    vecs[10] = mk(WB_LOAD, 1, 5'd13, 3'd7,   2'd2, 32'h0,         32'h0,         32'hCAFE_F00D, 1, 5'd13, 32'hCAFE_F00D);
    vecs[11] = mk(WB_LOAD, 1, 5'd0,  LD_LB,  2'd3, 32'h0,         32'h0,         32'h7F00_0000, 0, 5'd0,  32'h0000_007F);

    // Reset state
    #3;
    check("rst_ready", {31'd0, bus.ex_ready}, 32'd1);
    check("rst_regwrite", {31'd0, bus.regwrite}, 32'd0);
    check("rst_wreg", {27'd0, bus.wreg}, 32'd0);
    check("rst_wdata", bus.WriteData, 32'd0);
    check("rst_retire", {31'd0, bus.retire}, 32'd0);
    check("rst_perr", {31'd0, bus.protocol_err}, 32'd0);
    step();
    rst_n = 1'b1;

    // Table: one instruction each; loads get data on the first wait cycle.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wbsel, vecs[i].rw, vecs[i].rd, vecs[i].ldtype, vecs[i].addr_lo,
            vecs[i].alu, vecs[i].link);
      step();
      bus.ex_valid = 1'b0;
      if (vecs[i].wbsel == WB_LOAD) begin
        check($sformatf("v%0d_ready_wait", i), {31'd0, bus.ex_ready}, 32'd0);
        check($sformatf("v%0d_retire_wait", i), {31'd0, bus.retire}, 32'd0);
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = vecs[i].rdata;
        step();
        bus.dmem_rvalid = 1'b0;
      end
      check($sformatf("v%0d_regwrite", i), {31'd0, bus.regwrite}, {31'd0, vecs[i].exp_rw});
      check($sformatf("v%0d_wreg", i), {27'd0, bus.wreg}, {27'd0, vecs[i].exp_wreg});
      check($sformatf("v%0d_wdata", i), bus.WriteData, vecs[i].exp_wdata);
      check($sformatf("v%0d_retire", i), {31'd0, bus.retire}, 32'd1);
      check($sformatf("v%0d_perr", i), {31'd0, bus.protocol_err}, 32'd0);
    end

    // Back-to-back ALU writes, then pulses drop and wreg/WriteData hold.
    drive(WB_ALU, 1'b1, 5'd1, 3'd0, 2'd0, 32'd52, 32'd0);
    step();
    check("b2b0_regwrite", {31'd0, bus.regwrite}, 32'd1);
    check("b2b0_wreg", {27'd0, bus.wreg}, 32'd1);
    check("b2b0_wdata", bus.WriteData, 32'd52);
    drive(WB_ALU, 1'b1, 5'd2, 3'd0, 2'd0, 32'd78, 32'd0);
    step();
    bus.ex_valid = 1'b0;
    check("b2b1_regwrite", {31'd0, bus.regwrite}, 32'd1);
    check("b2b1_wreg", {27'd0, bus.wreg}, 32'd2);
    check("b2b1_wdata", bus.WriteData, 32'd78);
    step();
    check("b2b_idle_regwrite", {31'd0, bus.regwrite}, 32'd0);
    check("b2b_idle_retire", {31'd0, bus.retire}, 32'd0);
    check("b2b_hold_wreg", {27'd0, bus.wreg}, 32'd2);
    check("b2b_hold_wdata", bus.WriteData, 32'd78);

    // Loads whose data arrives three cycles after acceptance.
    load_seq("lb",  LD_LB,  2'd2, 5'd4, 32'h0080_0000, 2, 32'hFFFF_FF80);
    load_seq("lbu", LD_LBU, 2'd2, 5'd5, 32'h0080_0000, 2, 32'h0000_0080);
    load_seq("lhu", LD_LHU, 2'd2, 5'd6, 32'hBEEF_1234, 2, 32'h0000_BEEF);
    load_seq("lh",  LD_LH,  2'd2, 5'd7, 32'hBEEF_1234, 2, 32'hFFFF_BEEF);
    check("loads_perr", {31'd0, bus.protocol_err}, 32'd0);

    // Timeout: retire without a write exactly LT edges after acceptance.
    drive(WB_LOAD, 1'b1, 5'd9, LD_LW, 2'd0, 32'h0, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    for (int k = 1; k <= int'(LT); k++) begin
      step();
      check($sformatf("to%0d_retire", k), {31'd0, bus.retire}, {31'd0, k == int'(LT)});
      check($sformatf("to%0d_perr", k), {31'd0, bus.protocol_err}, {31'd0, k == int'(LT)});
      check($sformatf("to%0d_regwrite", k), {31'd0, bus.regwrite}, 32'd0);
    end
    check("to_ready", {31'd0, bus.ex_ready}, 32'd1);
    check("to_hold_wreg", {27'd0, bus.wreg}, 32'd7);
    step();
    step();
    check("to_perr_sticky", {31'd0, bus.protocol_err}, 32'd1);

    // Async reset mid-load abandons it; then stray rvalid in IDLE.
    drive(WB_LOAD, 1'b1, 5'd3, LD_LW, 2'd0, 32'h0, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, bus.ex_ready}, 32'd1);
    check("arst_perr", {31'd0, bus.protocol_err}, 32'd0);
    step();
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    step();
    bus.dmem_rvalid = 1'b0;
    check("stray_perr", {31'd0, bus.protocol_err}, 32'd1);
    check("stray_regwrite", {31'd0, bus.regwrite}, 32'd0);
    check("stray_retire", {31'd0, bus.retire}, 32'd0);
    check("stray_wdata", bus.WriteData, 32'd0);
    step();
    check("stray_perr_sticky", {31'd0, bus.protocol_err}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
